// File: rtl/adc_pkg.sv
// Shared definitions for the ADS1115 channel scanner: I2C instruction codes,
// register pointers, state encodings and the per-task I2C operation tables.
package adc_pkg;

  typedef enum logic [1:0] {
    I2C_START = 2'd0,
    I2C_STOP  = 2'd1,
    I2C_READ  = 2'd2,
    I2C_WRITE = 2'd3
  } i2c_instr_t;

  localparam logic [7:0] REG_CONVERSION = 8'h00;
  localparam logic [7:0] REG_CONFIG     = 8'h01;

  typedef enum logic [2:0] {
    IDLE, RUN_TASK, WAIT_I2C, INC_SUB, DELAY, NEXT_CH, DONE
  } scan_state_t;

  typedef enum logic [1:0] {
    TASK_SETUP, TASK_POLL, TASK_CHANGE_REG, TASK_READ
  } scan_task_t;

  typedef enum logic [1:0] {
    OP_IDLE, OP_WAIT_LOW, OP_WAIT_HIGH
  } op_state_t;

  function automatic logic [2:0] last_sub(scan_task_t t);
    case (t)
      TASK_SETUP:      return 3'd5;
      TASK_CHANGE_REG: return 3'd3;
      default:         return 3'd4;
    endcase
  endfunction

  function automatic i2c_instr_t op_instr(scan_task_t t, logic [2:0] sub);
    if (sub == 3'd0) return I2C_START;
    if (sub == last_sub(t)) return I2C_STOP;
    if ((t == TASK_POLL || t == TASK_READ) && sub >= 3'd2) return I2C_READ;
    return I2C_WRITE;
  endfunction

  function automatic logic [7:0] op_byte(scan_task_t t, logic [2:0] sub, logic [6:0] addr,
                                         logic [1:0] ch, logic [2:0] pga, logic [2:0] dr);
    logic [7:0] b;
    b = '0;
    case (sub)
      3'd1: b = {addr, (t == TASK_POLL || t == TASK_READ)};
      3'd2: begin
        if (t == TASK_SETUP) b = REG_CONFIG;
        else if (t == TASK_CHANGE_REG) b = REG_CONVERSION;
      end
      // Config MSB: single-shot start, single-ended mux on ch, PGA, single-shot mode
      3'd3: if (t == TASK_SETUP) b = {2'b11, ch, pga, 1'b1};
      3'd4: if (t == TASK_SETUP) b = {dr, 5'b00011};
      default: b = '0;
    endcase
    return b;
  endfunction

  // Lowest set mask bit at or above 'from'; result is {found, channel}.
  function automatic logic [2:0] next_channel(logic [3:0] mask, logic [2:0] from);
    logic [2:0] r;
    logic [1:0] c;
    r = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      c = 2'(3 - i);
      if (mask[c] && ({1'b0, c} >= from)) r = {1'b1, c};
    end
    return r;
  endfunction

endpackage

// File: rtl/adc_scanner_if.sv
// I2C byte-engine handshake bundle between a master sequencer and the bus engine.
interface adc_scanner_if;
  logic [1:0] instructionI2C;
  logic       enableI2C;
  logic [7:0] byteToSendI2C;
  logic [7:0] byteReceivedI2C;
  logic       completeI2C;

  modport master (output instructionI2C, enableI2C, byteToSendI2C,
                  input  byteReceivedI2C, completeI2C);
  modport slave  (input  instructionI2C, enableI2C, byteToSendI2C,
                  output byteReceivedI2C, completeI2C);
endinterface

// File: rtl/i2c_op_issuer.sv
// Issues one I2C engine instruction: raise enable, wait for complete low then high,
// drop enable and return the received byte with a one-cycle done strobe.
module i2c_op_issuer
  import adc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  i2c_instr_t  instr,
  input  logic [7:0]  tx_byte,
  output logic        done,
  output logic [7:0]  rx_byte,
  adc_scanner_if.master bus
);

  op_state_t state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= OP_IDLE;
      done               <= 1'b0;
      rx_byte            <= '0;
      bus.enableI2C      <= 1'b0;
      bus.instructionI2C <= '0;
      bus.byteToSendI2C  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        OP_IDLE: begin
          if (go) begin
            bus.instructionI2C <= instr;
            bus.byteToSendI2C  <= tx_byte;
            bus.enableI2C      <= 1'b1;
            state              <= OP_WAIT_LOW;
          end
        end
        OP_WAIT_LOW: begin
          if (!bus.completeI2C) state <= OP_WAIT_HIGH;
        end
        OP_WAIT_HIGH: begin
          if (bus.completeI2C) begin
            bus.enableI2C <= 1'b0;
            rx_byte       <= bus.byteReceivedI2C;
            done          <= 1'b1;
            state         <= OP_IDLE;
          end
        end
        default: state <= OP_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/adc_scanner.sv
// Scans the masked ADS1115 channels: configure, poll for conversion ready,
// point at the conversion register and read each result over I2C.
module adc_scanner
  import adc_pkg::*;
#(
  parameter logic [6:0]  ADDRESS    = 7'h48,
  parameter int unsigned POLL_DELAY = 255,
  parameter int unsigned MAX_POLLS  = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [3:0]  channelMask,
  input  logic        continuous,
  input  logic [2:0]  pga,
  input  logic [2:0]  dataRate,
  output logic        resultValid,
  output logic [1:0]  resultChannel,
  output logic [15:0] resultData,
  output logic        busy,
  output logic        scanDone,
  output logic        timeoutError,
  adc_scanner_if.master i2c
);

  localparam logic [15:0] DELAY_LAST = 16'(POLL_DELAY - 1);
  localparam logic [7:0]  POLL_LAST  = 8'(MAX_POLLS - 1);

  scan_state_t state;
  scan_task_t  task_q;
  logic [2:0]  sub;
  logic [15:0] delay_cnt;
  logic [7:0]  poll_cnt;
  logic [1:0]  ch;
  logic [3:0]  mask_q;
  logic        cont_q;
  logic [2:0]  pga_q;
  logic [2:0]  dr_q;
  logic [7:0]  msb_q;
  logic [7:0]  lsb_q;
  logic        delayed;
  logic        issue_go;
  i2c_instr_t  issue_instr;
  logic [7:0]  issue_tx;
  logic        op_done;
  logic [7:0]  op_rx;
  logic [2:0]  first_ch;
  logic [2:0]  after_ch;
  logic        start_req;

  always_comb begin
    first_ch  = next_channel(channelMask, 3'd0);
    after_ch  = next_channel(mask_q, {1'b0, ch} + 3'd1);
    start_req = enable && first_ch[2] && ((state == IDLE) || (state == DONE && cont_q));
  end

  i2c_op_issuer u_issuer (
    .clk     (clk),
    .reset   (reset),
    .go      (issue_go),
    .instr   (issue_instr),
    .tx_byte (issue_tx),
    .done    (op_done),
    .rx_byte (op_rx),
    .bus     (i2c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      task_q        <= TASK_SETUP;
      sub           <= '0;
      delay_cnt     <= '0;
      poll_cnt      <= '0;
      ch            <= '0;
      mask_q        <= '0;
      cont_q        <= 1'b0;
      pga_q         <= '0;
      dr_q          <= '0;
      msb_q         <= '0;
      lsb_q         <= '0;
      delayed       <= 1'b0;
      issue_go      <= 1'b0;
      issue_instr   <= I2C_START;
      issue_tx      <= '0;
      resultValid   <= 1'b0;
      resultChannel <= '0;
      resultData    <= '0;
      busy          <= 1'b0;
      scanDone      <= 1'b0;
      timeoutError  <= 1'b0;
    end else begin
      issue_go    <= 1'b0;
      resultValid <= 1'b0;
      scanDone    <= 1'b0;
      if (start_req) begin
        // Shared by a fresh start from IDLE and a continuous restart from DONE
        mask_q   <= channelMask;
        cont_q   <= continuous;
        pga_q    <= pga;
        dr_q     <= dataRate;
        ch       <= first_ch[1:0];
        task_q   <= TASK_SETUP;
        sub      <= '0;
        poll_cnt <= '0;
        delayed  <= 1'b0;
        busy     <= 1'b1;
        state    <= RUN_TASK;
        if (state == IDLE) timeoutError <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          RUN_TASK: begin
            if (task_q == TASK_POLL && sub == '0 && !delayed) begin
              delay_cnt <= '0;
              state     <= DELAY;
            end else begin
              issue_go    <= 1'b1;
              issue_instr <= op_instr(task_q, sub);
              issue_tx    <= op_byte(task_q, sub, ADDRESS, ch, pga_q, dr_q);
              state       <= WAIT_I2C;
            end
          end
          DELAY: begin
            if (delay_cnt == DELAY_LAST) begin
              delayed <= 1'b1;
              state   <= RUN_TASK;
            end else begin
              delay_cnt <= delay_cnt + 16'd1;
            end
          end
          WAIT_I2C: begin
            if (op_done) begin
              if (issue_instr == I2C_READ) begin
                if (sub == 3'd2) msb_q <= op_rx;
                else lsb_q <= op_rx;
              end
              state <= INC_SUB;
            end
          end
          INC_SUB: begin
            if (sub != last_sub(task_q)) begin
              sub   <= sub + 3'd1;
              state <= RUN_TASK;
            end else begin
              sub <= '0;
              case (task_q)
                TASK_SETUP: begin
                  task_q  <= TASK_POLL;
                  delayed <= 1'b0;
                  state   <= RUN_TASK;
                end
                TASK_POLL: begin
                  delayed <= 1'b0;
                  if (msb_q[7]) begin
                    task_q <= TASK_CHANGE_REG;
                    state  <= RUN_TASK;
                  end else if (poll_cnt == POLL_LAST) begin
                    timeoutError <= 1'b1;
                    state        <= NEXT_CH;
                  end else begin
                    poll_cnt <= poll_cnt + 8'd1;
                    state    <= RUN_TASK;
                  end
                end
                TASK_CHANGE_REG: begin
                  task_q <= TASK_READ;
                  state  <= RUN_TASK;
                end
                default: begin
                  resultValid   <= 1'b1;
                  resultChannel <= ch;
                  resultData    <= {msb_q, lsb_q};
                  state         <= NEXT_CH;
                end
              endcase
            end
          end
          NEXT_CH: begin
            if (after_ch[2]) begin
              ch       <= after_ch[1:0];
              task_q   <= TASK_SETUP;
              poll_cnt <= '0;
              delayed  <= 1'b0;
              state    <= RUN_TASK;
            end else begin
              scanDone <= 1'b1;
              state    <= DONE;
            end
          end
          DONE: begin
            if (!enable) begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_scanner.sv
// Bench for adc_scanner: an ADS1115-like I2C slave model predicts results into a
// scoreboard queue; a monitor pops and compares on every resultValid/scanDone.
module tb_adc_scanner;

  localparam int unsigned MAXP = 3;
  localparam logic [6:0]  ADDR = 7'h48;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [3:0]  channelMask = '0;
  logic        continuous = 1'b0;
  logic [2:0]  pga = '0;
  logic [2:0]  dataRate = '0;
  logic        resultValid;
  logic [1:0]  resultChannel;
  logic [15:0] resultData;
  logic        busy;
  logic        scanDone;
  logic        timeoutError;

  adc_scanner_if i2c();

  adc_scanner #(.ADDRESS(ADDR), .POLL_DELAY(4), .MAX_POLLS(MAXP)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .channelMask  (channelMask),
    .continuous   (continuous),
    .pga          (pga),
    .dataRate     (dataRate),
    .resultValid  (resultValid),
    .resultChannel(resultChannel),
    .resultData   (resultData),
    .busy         (busy),
    .scanDone     (scanDone),
    .timeoutError (timeoutError),
    .i2c          (i2c)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int test_id = 0;
  int ready_after = 1;
  logic        use_fixed = 1'b0;
  logic [15:0] fixed_data = '0;
  logic [17:0] exp_q[$];
  int polls = 0;
  logic [7:0] last_cfg_hi = '0;
  logic [7:0] last_cfg_lo = '0;
  int n_results = 0;
  int n_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ADS1115 slave model: tracks the register pointer, answers polls and conversion reads
  initial begin : slave
    int seen_id, prev_ch, exp_ch, idx, rd_idx, wait_n, t;
    logic rw;
    logic [7:0] ptr, cfg_hi, cfg_lo, resp;
    logic [15:0] cur_data;
    seen_id = -1; prev_ch = -1; idx = 0; rd_idx = 0; rw = 1'b0;
    ptr = '0; cfg_hi = '0; cfg_lo = '0; cur_data = '0;
    i2c.completeI2C = 1'b1;
    i2c.byteReceivedI2C = '0;
    forever begin
      @(negedge clk);
      if (i2c.enableI2C === 1'b1) begin
        resp = 8'h00;
        case (i2c.instructionI2C)
          2'd0: begin idx = 0; rd_idx = 0; end
          2'd3: begin
            if (idx == 0) begin
              check("slave_addr", i2c.byteToSendI2C[7:1], ADDR);
              rw = i2c.byteToSendI2C[0];
            end else if (!rw) begin
              if (idx == 1) ptr = i2c.byteToSendI2C;
              else if (idx == 2) cfg_hi = i2c.byteToSendI2C;
              else if (idx == 3) cfg_lo = i2c.byteToSendI2C;
            end
            idx++;
          end
          2'd2: begin
            if (ptr == 8'h01) begin
              if (rd_idx == 0) begin
                polls++;
                resp = {(polls >= ready_after), 7'($urandom)};
              end else begin
                resp = 8'($urandom);
              end
            end else begin
              resp = (rd_idx == 0) ? cur_data[15:8] : cur_data[7:0];
            end
            rd_idx++;
          end
          default: begin
            if (!rw && ptr == 8'h01 && idx == 4) begin
              if (seen_id != test_id) begin seen_id = test_id; prev_ch = -1; end
              exp_ch = -1;
              for (int c = prev_ch + 1; c < 4; c++) if (channelMask[c] && exp_ch < 0) exp_ch = c;
              for (int c = 0; c < 4; c++) if (channelMask[c] && exp_ch < 0) exp_ch = c;
              check("cfg_hi", cfg_hi, {2'b11, 2'(exp_ch), pga, 1'b1});
              check("cfg_lo", cfg_lo, {dataRate, 5'b00011});
              last_cfg_hi = cfg_hi;
              last_cfg_lo = cfg_lo;
              polls = 0;
              cur_data = use_fixed ? fixed_data : 16'($urandom);
              if (ready_after <= int'(MAXP)) exp_q.push_back({2'(exp_ch), cur_data});
              prev_ch = exp_ch;
            end
          end
        endcase
        i2c.completeI2C = 1'b0;
        wait_n = $urandom_range(1, 3);
        repeat (wait_n) @(negedge clk);
        i2c.byteReceivedI2C = resp;
        i2c.completeI2C = 1'b1;
        t = 0;
        while (i2c.enableI2C && t < 20) begin @(negedge clk); t++; end
        check("enable_release", i2c.enableI2C, 1'b0);
      end
    end
  end

  initial begin : monitor
    logic [17:0] e;
    forever begin
      @(negedge clk);
      if (resultValid) begin
        check("result_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("result_ch", resultChannel, e[17:16]);
          check("result_data", resultData, e[15:0]);
        end
        n_results++;
      end
      if (scanDone) begin
        check("timeout_flag", timeoutError, ready_after > int'(MAXP));
        check("pending_results", exp_q.size(), 0);
        n_done++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input int target, input string name);
    int t = 0;
    while (n_done < target && t < 20000) begin @(negedge clk); t++; end
    check(name, n_done >= target, 1'b1);
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (busy && t < 5000) begin @(negedge clk); t++; end
    check(name, busy, 1'b0);
  endtask

  task automatic run_pass(input logic [3:0] mask, input logic [2:0] p, input logic [2:0] dr,
                          input int ra, input logic [15:0] fd, input logic uf);
    int d0, r0;
    channelMask = mask; pga = p; dataRate = dr; continuous = 1'b0;
    ready_after = ra; fixed_data = fd; use_fixed = uf;
    test_id++;
    d0 = n_done; r0 = n_results;
    enable = 1'b1;
    wait_done(d0 + 1, "scan_done_seen");
    enable = 1'b0;
    wait_idle("return_idle");
    tick(3);
    check("done_count", n_done - d0, 1);
    check("result_count", n_results - r0, (ra <= int'(MAXP)) ? $countones(mask) : 0);
  endtask

  initial begin : main
    int d0, r0, t;
    logic activity;
    tick(3);
    check("rst_busy", busy, 1'b0);
    check("rst_valid", resultValid, 1'b0);
    check("rst_done", scanDone, 1'b0);
    check("rst_timeout", timeoutError, 1'b0);
    check("rst_en_i2c", i2c.enableI2C, 1'b0);
    check("rst_instr", i2c.instructionI2C, 2'd0);
    check("rst_tx_byte", i2c.byteToSendI2C, 8'd0);
    check("rst_data", resultData, 16'd0);
    check("rst_channel", resultChannel, 2'd0);
    reset = 1'b0;
    tick(2);

    channelMask = 4'b0000;
    enable = 1'b1;
    activity = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (busy || i2c.enableI2C || resultValid || scanDone) activity = 1'b1;
    end
    check("empty_mask_activity", activity, 1'b0);
    enable = 1'b0;
    tick(2);

    run_pass(4'b0101, 3'b000, 3'b000, 1, 16'h1234, 1'b1);
    run_pass(4'b0010, 3'b001, 3'b100, 2, 16'h0000, 1'b0);
    check("cfg_hi_literal", last_cfg_hi, 8'hD3);
    check("cfg_lo_literal", last_cfg_lo, 8'h83);

    run_pass(4'b0001, 3'b000, 3'b000, 99, 16'h0000, 1'b0);
    check("poll_count", polls, MAXP);
    check("timeout_sticky", timeoutError, 1'b1);

    for (int i = 0; i < 6; i++) begin
      run_pass(4'($urandom_range(1, 15)), 3'($urandom), 3'($urandom),
               (i == 0) ? 1 : $urandom_range(1, 4), 16'h0000, 1'b0);
    end

    channelMask = 4'b1000; continuous = 1'b1; ready_after = 2; use_fixed = 1'b0;
    test_id++;
    d0 = n_done; r0 = n_results;
    enable = 1'b1;
    wait_done(d0 + 3, "cont_three_passes");
    tick(5);
    enable = 1'b0;
    wait_idle("cont_return_idle");
    tick(3);
    check("cont_done_count", n_done - d0, 4);
    check("cont_result_count", n_results - r0, 4);
    continuous = 1'b0;

    channelMask = 4'b0001; ready_after = 1;
    test_id++;
    enable = 1'b1;
    t = 0;
    while (!i2c.enableI2C && t < 200) begin @(negedge clk); t++; end
    check("reached_wait_i2c", i2c.enableI2C, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_en_i2c", i2c.enableI2C, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_data", resultData, 16'd0);
    check("midrst_timeout", timeoutError, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    enable = 1'b0;
    tick(5);
    check("midrst_stays_idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
